// File: rtl/cursor_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cursor_pkg : shared FSM encoding, coordinate sizing and saturating step   rev 1.0
// ----------------------------------------------------------------------------
package cursor_pkg;

  localparam int COORD_W = 6;
  localparam int X_MAX   = 63;
  localparam int Y_MAX   = 63;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_KICK      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WAIT_CLR  = 3'd4
  } state_t;

  function automatic coord_t sat_step(coord_t v, logic req, logic inc, coord_t vmax);
    if (!req) return v;
    if (inc) return (v >= vmax) ? vmax : v + 1'b1;
    return (v == '0) ? v : v - 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_move_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cursor_move_ctrl_if : position/draw handshake toward the cursor draw stage  rev 1.0
// ----------------------------------------------------------------------------
interface cursor_move_ctrl_if;
  import cursor_pkg::*;

  coord_t pos_x;
  coord_t pos_y;
  logic   draw_init;
  logic   cursor_done;

  modport master (output pos_x, output pos_y, output draw_init, input cursor_done);
  modport slave  (input pos_x, input pos_y, input draw_init, output cursor_done);
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_debounce : 2-FF synchroniser, stability counter, debounced level + rise pulse  rev 1.0
// ----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);
  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronised samples that disagree with level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      rise <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync[1];
          rise  <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/cursor_move_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cursor_move_ctrl : debounced buttons -> saturating cursor steps with auto-repeat,
//                    one draw_init per move and cursor_done handshake   rev 1.0
// ----------------------------------------------------------------------------
module cursor_move_ctrl
  import cursor_pkg::*;
#(
  parameter int INIT_X     = 32,
  parameter int INIT_Y     = 32,
  parameter int DEB_CYCLES = 50000,
  parameter int RPT_DELAY  = 6000000,
  parameter int RPT_RATE   = 1500000,
  parameter int TIMEOUT    = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               enable,
  cursor_move_ctrl_if.master dif,
  output logic               busy,
  output logic               timeout_err
);
  localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);
  localparam int TMO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [3:0]       raw, lvl, rise;
  logic [1:0]       req, inc, pend, pend_inc, step_req, step_inc;
  state_t           state, state_nx;
  logic [TMO_W-1:0] tmo_cnt;
  coord_t           pos_x, pos_y;
  logic             draw_init, apply, tmo_hit;

  // bit order: up, down, left, right
  assign raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (raw[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end

  // axis 0 = x (left/right), axis 1 = y (up/down); index PI is the incrementing button
  for (genvar a = 0; a < 2; a++) begin : g_axis
    localparam int NI = (a == 0) ? 2 : 0;
    localparam int PI = NI + 1;
    logic             held_one, press, rpt_on;
    logic [CNT_W-1:0] rpt_cnt;

    assign held_one = enable && (lvl[NI] ^ lvl[PI]);
    assign press    = lvl[PI] ? rise[PI] : rise[NI];
    assign inc[a]   = lvl[PI];
    assign req[a]   = held_one && (press ||
                      (!rpt_on && rpt_cnt == CNT_W'(RPT_DELAY)) ||
                      ( rpt_on && rpt_cnt == CNT_W'(RPT_RATE)));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rpt_cnt <= '0;
        rpt_on  <= 1'b0;
      end else if (!held_one) begin
        rpt_cnt <= '0;
        rpt_on  <= 1'b0;
      end else if (press) begin
        rpt_cnt <= CNT_W'(1);
        rpt_on  <= 1'b0;
      end else if (req[a]) begin
        rpt_cnt <= CNT_W'(1);
        rpt_on  <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  // a pending step takes precedence over a fresh request on the same axis
  assign step_req = pend | req;
  assign step_inc = (pend & pend_inc) | (~pend & inc);

  always_comb begin
    state_nx  = state;
    draw_init = 1'b0;
    apply     = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_BOOT: state_nx = ST_KICK;
      ST_IDLE: begin
        if (|step_req) begin
          apply    = 1'b1;
          state_nx = ST_KICK;
        end
      end
      ST_KICK: begin
        draw_init = 1'b1;
        state_nx  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (dif.cursor_done) begin
          state_nx = ST_WAIT_CLR;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          tmo_hit  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT_CLR: if (!dif.cursor_done) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_BOOT;
      pos_x       <= coord_t'(INIT_X);
      pos_y       <= coord_t'(INIT_Y);
      pend        <= '0;
      pend_inc    <= '0;
      tmo_cnt     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_nx;
      busy    <= (state_nx != ST_IDLE);
      tmo_cnt <= (state == ST_WAIT_DONE) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) timeout_err <= 1'b1;
      if (apply) begin
        pos_x <= sat_step(pos_x, step_req[0], step_inc[0], coord_t'(X_MAX));
        pos_y <= sat_step(pos_y, step_req[1], step_inc[1], coord_t'(Y_MAX));
        pend  <= '0;
      end else if (state != ST_IDLE) begin
        for (int a = 0; a < 2; a++) begin
          if (req[a] && !pend[a]) begin
            pend[a]     <= 1'b1;
            pend_inc[a] <= inc[a];
          end
        end
      end
    end
  end

  assign dif.pos_x     = pos_x;
  assign dif.pos_y     = pos_y;
  assign dif.draw_init = draw_init;
endmodule
`default_nettype wire

// File: tb/tb_cursor_move_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cursor_move_ctrl : directed + random button stimulus against a behavioural model  rev 1.0
// ----------------------------------------------------------------------------
module tb_cursor_move_ctrl;
  localparam int DEB = 4, DLY = 20, RATE = 8, TMO = 50;
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3;
  localparam int P_BOOT = 0, P_IDLE = 1, P_KICK = 2, P_WAIT = 3, P_CLR = 4;

  logic clk = 1'b0, rst = 1'b0, enable = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic busy, timeout_err;
  int   total = 0, bad = 0, draws = 0;
  bit   done_en = 1'b1;

  cursor_move_ctrl_if dif();

  cursor_move_ctrl #(
    .INIT_X(32), .INIT_Y(32), .DEB_CYCLES(DEB),
    .RPT_DELAY(DLY), .RPT_RATE(RATE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .enable(enable),
    .dif(dif), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (updated on each rising edge) -------
  int  m_x, m_y, ph;
  bit  m_err, m_busy;

  initial begin : model
    bit     raw [4];
    bit     lvl [4], rse [4];
    bit     hist [4][DEB+2];
    bit     pend [2];
    int     pdir [2], prev_key [2], rq [2], dr [2];
    longint start [2];
    bit     edg [2];
    longint cyc, d;
    int     wc, old_ph, ni, pi, key, s0, s1;
    bit     rose, all_diff;
    cyc = 0;
    forever begin
      @(posedge clk);
      raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_left; raw[3] = btn_right;
      if (!rst) begin
        m_x = 32; m_y = 32; m_err = 0; m_busy = 0; ph = P_BOOT; wc = 0;
        for (int a = 0; a < 2; a++) begin
          pend[a] = 0; pdir[a] = 0; prev_key[a] = 0; start[a] = 0; edg[a] = 0;
        end
        for (int b = 0; b < 4; b++) begin
          lvl[b] = 0; rse[b] = 0;
          for (int k = 0; k < DEB + 2; k++) hist[b][k] = 0;
        end
      end else begin
        old_ph = ph;
        // a "run" is an uninterrupted stretch of one button held on an axis
        for (int a = 0; a < 2; a++) begin
          ni   = (a == 0) ? B_LEFT : B_UP;
          pi   = ni + 1;
          key  = (enable && (lvl[ni] != lvl[pi])) ? (lvl[pi] ? 2 : 1) : 0;
          rose = lvl[pi] ? rse[pi] : rse[ni];
          if (key != 0 && (key != prev_key[a] || rose)) begin
            start[a] = cyc; edg[a] = rose;
          end
          prev_key[a] = key;
          d     = cyc - start[a];
          rq[a] = (key != 0) && ((edg[a] && d == 0) || d == DLY ||
                                 (d > DLY && (d - DLY) % RATE == 0));
          dr[a] = (key == 2) ? 1 : -1;
        end
        case (ph)
          P_BOOT: ph = P_KICK;
          P_IDLE: begin
            if (pend[0] || pend[1] || rq[0] || rq[1]) begin
              s0 = pend[0] ? pdir[0] : (rq[0] ? dr[0] : 0);
              s1 = pend[1] ? pdir[1] : (rq[1] ? dr[1] : 0);
              m_x = m_x + s0; if (m_x < 0) m_x = 0; if (m_x > 63) m_x = 63;
              m_y = m_y + s1; if (m_y < 0) m_y = 0; if (m_y > 63) m_y = 63;
              pend[0] = 0; pend[1] = 0;
              ph = P_KICK;
            end
          end
          P_KICK: begin ph = P_WAIT; wc = 0; end
          P_WAIT: begin
            if (dif.cursor_done) ph = P_CLR;
            else begin
              wc++;
              if (wc == TMO) begin m_err = 1; ph = P_IDLE; end
            end
          end
          default: if (!dif.cursor_done) ph = P_IDLE;
        endcase
        if (old_ph != P_IDLE)
          for (int a = 0; a < 2; a++)
            if (rq[a] != 0 && !pend[a]) begin pend[a] = 1; pdir[a] = dr[a]; end
        m_busy = (ph != P_IDLE);
        // debounced level flips once DEB consecutive synchronised samples disagree
        for (int b = 0; b < 4; b++) begin
          for (int k = DEB + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
          hist[b][0] = raw[b];
          all_diff = 1;
          for (int k = 2; k < DEB + 2; k++) if (hist[b][k] == lvl[b]) all_diff = 0;
          rse[b] = all_diff && !lvl[b];
          if (all_diff) lvl[b] = !lvl[b];
        end
        cyc++;
      end
    end
  end

  // ---------------- per-cycle compare ------------------------------------
  initial begin : compare
    logic [5:0] ex, ey;
    logic       ed, eb, ee;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        ex = 6'd32; ey = 6'd32; ed = 0; eb = 0; ee = 0;
      end else begin
        ex = 6'(m_x); ey = 6'(m_y); ed = (ph == P_KICK); eb = m_busy; ee = m_err;
      end
      if (dif.draw_init === 1'b1) draws++;
      total++;
      if (dif.pos_x !== ex || dif.pos_y !== ey || dif.draw_init !== ed ||
          busy !== eb || timeout_err !== ee) begin
        bad++;
        $display("FAIL cycle t=%0t got x=%0d y=%0d init=%b busy=%b err=%b want x=%0d y=%0d init=%b busy=%b err=%b",
                 $time, dif.pos_x, dif.pos_y, dif.draw_init, busy, timeout_err, ex, ey, ed, eb, ee);
      end
    end
  end

  // ---------------- draw-stage model --------------------------------------
  initial begin : draw_stage
    int dly, hold;
    dly = 0; hold = 0;
    dif.cursor_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        dif.cursor_done = 1'b0; dly = 0; hold = 0;
      end else begin
        if (hold > 0) begin hold--; if (hold == 0) dif.cursor_done = 1'b0; end
        if (dly > 0) begin dly--; if (dly == 0) begin dif.cursor_done = 1'b1; hold = 25; end end
        if (dif.draw_init === 1'b1 && done_en) dly = 5;
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_UP:    btn_up    = v;
      B_DOWN:  btn_down  = v;
      B_LEFT:  btn_left  = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic press(input int b, input int n);
    @(negedge clk);
    set_btn(b, 1'b1);
    cyc_n(n);
    set_btn(b, 1'b0);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic wait_idle();
    int quiet, n;
    quiet = 0; n = 0;
    cyc_n(8);
    while (quiet < 10 && n < 600) begin
      @(negedge clk);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    if (quiet < 10) begin
      total++; bad++;
      $display("FAIL wait_idle busy=%b after %0d cycles want 0", busy, n);
    end
  endtask

  // ---------------- directed + random sequence ----------------------------
  initial begin : stim
    int n, m, b1, b2;
    cyc_n(3);
    rst = 1'b1;
    wait_idle();
    chk("t1_pos_x", int'(dif.pos_x), 32);
    chk("t1_pos_y", int'(dif.pos_y), 32);
    chk("t1_draws", draws, 1);
    chk("t1_busy", int'(busy), 0);

    draws = 0; press(B_RIGHT, 10); wait_idle();
    chk("t2_pos_x", int'(dif.pos_x), 33);
    chk("t2_draws", draws, 1);
    draws = 0; press(B_RIGHT, 2); wait_idle();
    chk("t2_glitch_x", int'(dif.pos_x), 33);
    chk("t2_glitch_draws", draws, 0);

    for (int i = 0; i < 40 && dif.pos_x > 1; i++) begin press(B_LEFT, 6); wait_idle(); end
    chk("t3_start_x", int'(dif.pos_x), 1);
    draws = 0; press(B_LEFT, 60); wait_idle();
    chk("t3_sat_x", int'(dif.pos_x), 0);
    chk("t3_redraws", int'(draws >= 2), 1);

    draws = 0;
    @(negedge clk); btn_up = 1; btn_down = 1;
    cyc_n(40); btn_up = 0; btn_down = 0;
    wait_idle();
    chk("t4_updown_y", int'(dif.pos_y), 32);
    chk("t4_updown_draws", draws, 0);
    draws = 0;
    @(negedge clk); btn_up = 1; btn_right = 1;
    cyc_n(10); btn_up = 0; btn_right = 0;
    wait_idle();
    chk("t4_diag_x", int'(dif.pos_x), 1);
    chk("t4_diag_y", int'(dif.pos_y), 31);
    chk("t4_diag_draws", draws, 1);

    draws = 0;
    press(B_RIGHT, 10);
    press(B_UP, 6);
    cyc_n(4);
    press(B_UP, 6);
    cyc_n(2);
    chk("t5_held_y", int'(dif.pos_y), 31);
    chk("t5_busy", int'(busy), 1);
    wait_idle();
    chk("t5_x", int'(dif.pos_x), 2);
    chk("t5_y", int'(dif.pos_y), 30);
    chk("t5_draws", draws, 2);

    done_en = 0;
    @(negedge clk); btn_right = 1;
    n = 0;
    while (dif.draw_init !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    btn_right = 0;
    m = 0;
    while (timeout_err !== 1'b1 && m < 200) begin @(negedge clk); m++; end
    chk("t6_tmo_cycles", m, 51);
    chk("t6_tmo_err", int'(timeout_err), 1);
    chk("t6_idle", int'(busy), 0);
    chk("t6_x", int'(dif.pos_x), 3);
    @(negedge clk); btn_right = 1;
    cyc_n(8); btn_right = 0;
    cyc_n(10);
    rst = 1'b0;
    #1;
    chk("t6_rst_x", int'(dif.pos_x), 32);
    chk("t6_rst_y", int'(dif.pos_y), 32);
    chk("t6_rst_init", int'(dif.draw_init), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_err", int'(timeout_err), 0);
    cyc_n(2);
    done_en = 1;
    rst = 1'b1;
    wait_idle();

    for (int it = 0; it < 60; it++) begin
      b1 = $urandom_range(0, 3);
      b2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : b1;
      @(negedge clk);
      enable = ($urandom_range(0, 9) != 0);
      set_btn(b1, 1'b1);
      set_btn(b2, 1'b1);
      cyc_n($urandom_range(1, 45));
      set_btn(b1, 1'b0);
      set_btn(b2, 1'b0);
      cyc_n($urandom_range(0, 30));
    end
    enable = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
